// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry and Gray-code helpers.
// The write-side and read-side pointer blocks both import this package.
package fifo_pkg;

  localparam int ADDRSIZE_DEF     = 8;
  localparam int AFULL_THRESH_DEF = 252;

  // Pointers up to 32 bits wide are handled here. A narrower Gray value
  // can be zero-extended on the way in and truncated on the way out,
  // because leading zeros do not change the Gray<->binary mapping.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/sync_r2w.sv
// Two-flop synchroniser that brings the read-domain Gray pointer into wclk.
// Because the input is a Gray code, at most one bit is in flight at a time,
// so a per-bit synchroniser yields either the old or the new pointer.
module sync_r2w #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [1:0][W-1:0] stg;

  // Shift the pointer through two flops; clear both on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stg <= '0;
    else        stg <= {stg[0], d};
  end

  assign q = stg[1];

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full logic of an asynchronous FIFO.
// Holds the binary write counter, publishes its Gray form to the read side,
// and derives full, almost-full and fill level from the synchronised read
// pointer. Status is pessimistic: a read only frees space once the updated
// read pointer has passed the synchroniser.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE     = ADDRSIZE_DEF,
  parameter int AFULL_THRESH = AFULL_THRESH_DEF
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic                wclken,
  output logic                wfull,
  output logic [ADDRSIZE:0]   wptr,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel
);

  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] wq2_rptr;
  logic [PW-1:0] rbin;
  logic [PW-1:0] full_cmp;
  logic [PW-1:0] wlevel_next;
  logic          accept;

  sync_r2w #(.W(PW)) u_sync_r2w (
    .clk   (wclk),
    .rst_n (wrst_n),
    .d     (rptr),
    .q     (wq2_rptr)
  );

  // Next-state pointer arithmetic; writes while full are dropped here
  always_comb begin
    accept      = winc & ~wfull;
    wbin_next   = wbin + PW'(accept);
    wgray_next  = PW'(bin2gray(32'(wbin_next)));
    rbin        = PW'(gray2bin(32'(wq2_rptr)));
    // Full when the write pointer has lapped the read pointer once:
    // in Gray form that is the top two bits inverted, the rest equal.
    full_cmp    = {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]};
    wlevel_next = wbin_next - rbin;
  end

  // Register counter, published pointer and all status flags
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      wlevel       <= '0;
      walmost_full <= 1'b0;
    end else begin
      wbin         <= wbin_next;
      wptr         <= wgray_next;
      wfull        <= (wgray_next == full_cmp);
      wlevel       <= wlevel_next;
      walmost_full <= (wlevel_next >= PW'(AFULL_THRESH));
    end
  end

  assign waddr  = wbin[ADDRSIZE-1:0];
  assign wclken = accept;

endmodule

// File: doc/fifo_wptr_full.md
FIFO_WPTR_FULL -- requirements
Module: fifo_wptr_full

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 8, meaning the RAM address width; FIFO depth is 2^ADDRSIZE = 256.
REQ-002 SHALL have parameter AFULL_THRESH, default 252, meaning the fill level at which walmost_full asserts.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port wclk  input  1  write-domain clock, all state on rising edge.
REQ-005 SHALL have port wrst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port winc  input  1  write request for this cycle.
REQ-007 SHALL have port rptr  input  ADDRSIZE+1  Gray read pointer from the read domain; asynchronous to wclk.
REQ-008 SHALL have port waddr  output  ADDRSIZE  RAM write address.
REQ-009 SHALL have port wclken  output  1  RAM write enable.
REQ-010 SHALL have port wfull  output  1  FIFO full; also drives RAM wfull.
REQ-011 SHALL have port wptr  output  ADDRSIZE+1  registered Gray write pointer to the read domain.
REQ-012 SHALL have port walmost_full  output  1  fill level >= AFULL_THRESH.
REQ-013 SHALL have port wlevel  output  ADDRSIZE+1  registered fill level as seen by the write side.

Function
REQ-014 SHALL synchronise rptr through two wclk flops to give wq2_rptr, with 2-cycle latency.
REQ-015 SHALL accept a write only when winc=1 and wfull=0: wclken = winc & ~wfull, combinational.
REQ-016 SHALL hold an (ADDRSIZE+1)-bit binary write counter wbin: wbin_next = wbin + accept, wrapping modulo 2^(ADDRSIZE+1) with no saturation.
REQ-017 SHALL drive waddr = wbin[ADDRSIZE-1:0] directly from the register, so the address wraps from 255 to 0.
REQ-018 SHALL update wptr to (wbin_next>>1)^wbin_next each cycle; consecutive wptr values differ by at most one bit.
REQ-019 SHALL register wfull <= (Gray(wbin_next) == {~wq2_rptr[MSB:MSB-1], wq2_rptr[MSB-2:0]}).
REQ-020 SHALL compute wlevel <= wbin_next - gray2bin(wq2_rptr), modulo 2^(ADDRSIZE+1), with a range of 0..2^ADDRSIZE.
REQ-021 SHALL register walmost_full <= (wlevel_next >= AFULL_THRESH).
REQ-022 SHALL ignore winc while full: counters, waddr and wptr hold, and wclken=0.
REQ-023 SHALL keep wfull asserted until a changed wq2_rptr is visible; deassertion is pessimistic (3 wclk after rptr changes).
REQ-024 SHALL, when a write and a read-pointer update coincide, evaluate the full comparison on wbin_next against the current wq2_rptr; no priority beyond that.

Reset
REQ-025 SHALL, while wrst_n=0, clear wbin, wptr, both synchroniser flops, wlevel, wfull and walmost_full to 0; waddr therefore reads 0 and wclken = 0 when winc=0.
REQ-026 SHALL apply reset immediately, even mid-operation, and release it synchronously to the first wclk edge after deassertion.

Structure
REQ-027 SHALL place the ADDRSIZE default, AFULL_THRESH default and a Gray-to-binary function in shared package fifo_pkg, which the read-side block reuses.
REQ-028 SHALL instantiate sub-module sync_r2w (parameterised 2-flop synchroniser, async active-low reset) for rptr.
REQ-029 SHALL contain no RAM; RAM remains a separate module fed by waddr/wclken/wfull.

Verification
REQ-030 SHALL verify: reset with rptr=0, then 256 consecutive winc -> wclken high 256 cycles, waddr 0..255, wfull=1 on the edge after the 256th accept, wlevel=256.
REQ-031 SHALL verify: a 257th winc while full -> wclken=0, waddr stays 0, wptr unchanged (Gray of 256 = 9'h180).
REQ-032 SHALL verify: from full, rptr stepped to Gray(1)=9'h001 -> wfull deasserts exactly 3 wclk later and wlevel=255.
REQ-033 SHALL verify: with AFULL_THRESH=252 and rptr=0, after 252 accepts -> walmost_full=1 on that edge, and it is 0 after 251.
REQ-034 SHALL verify: wrst_n pulsed low after 100 writes -> all outputs 0 immediately without a clock edge, and writing resumes at waddr 0.
REQ-035 SHALL verify: over 1024 writes with rptr tracking -> every wptr transition is a single-bit change and the pointer wraps from 9'h100 back to 0.
